// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit: Moore step FSM plus combinational ALU decoder.
// Latency: one state per clk; outputs are combinational from state/op/funct/zero.
// Backpressure: none; the datapath advances every cycle the FSM does.
module mips_multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JEX     = 4'd11;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [3:0] nextstate;
  logic [3:0] dstate;
  logic       pcwrite;
  logic       branch;
  logic       bad_state;
  logic       memwrite_raw;
  logic       irwrite_raw;
  logic       regwrite_raw;
  logic [1:0] aluop;

  // State register; a low reset returns to FETCH on the next edge.
  always_ff @(posedge clk) begin
    if (!reset) state <= FETCH;
    else        state <= nextstate;
  end

  // Step sequencing; unknown opcodes and unreachable codes fall back to FETCH.
  always_comb begin
    nextstate = FETCH;
    case (state)
      FETCH:   nextstate = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nextstate = MEMADR;
          OP_RTYPE:     nextstate = RTYPEEX;
          OP_BEQ:       nextstate = BEQEX;
          OP_ADDI:      nextstate = ADDIEX;
          OP_J:         nextstate = JEX;
          default:      nextstate = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_LW)      nextstate = MEMRD;
        else if (op == OP_SW) nextstate = MEMWR;
        else                  nextstate = FETCH;
      end
      MEMRD:   nextstate = MEMWB;
      RTYPEEX: nextstate = RTYPEWB;
      ADDIEX:  nextstate = ADDIWB;
      default: nextstate = FETCH;
    endcase
  end

  // While reset is held the datapath sees FETCH-style selects with strobes masked.
  assign dstate = reset ? state : FETCH;

  // Per-step control decode.
  always_comb begin
    pcwrite      = 1'b0;
    branch       = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    iord         = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    aluop        = 2'b00;
    bad_state    = 1'b0;
    case (dstate)
      FETCH: begin
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
        alusrcb     = 2'b01;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:  regwrite_raw = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: bad_state = 1'b1;
    endcase
  end

  // ALU decoder; unsupported funct yields 011 so the ALU returns 0.
  always_comb begin
    alucontrol = 3'b010;
    if (bad_state) begin
      alucontrol = 3'b000;
    end else begin
      case (aluop)
        2'b00: alucontrol = 3'b010;
        2'b01: alucontrol = 3'b110;
        default: begin
          case (funct)
            6'b100000: alucontrol = 3'b010;
            6'b100010: alucontrol = 3'b110;
            6'b100100: alucontrol = 3'b000;
            6'b100101: alucontrol = 3'b001;
            6'b101010: alucontrol = 3'b111;
            default:   alucontrol = 3'b011;
          endcase
        end
      endcase
    end
  end

  assign pcen     = reset & (pcwrite | (branch & zero));
  assign memwrite = reset & memwrite_raw;
  assign irwrite  = reset & irwrite_raw;
  assign regwrite = reset & regwrite_raw;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for the multicycle MIPS controller: directed and random instruction streams.
// Expected step sequences and per-step controls come from an instruction-level model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  int seq[$];

  always #5 clk = ~clk;

  mips_multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .iord(iord),
    .memtoreg(memtoreg), .regdst(regdst), .alucontrol(alucontrol), .state(state)
  );

  // Output bundle: {pcen,memwrite,irwrite,regwrite,alusrca,alusrcb,pcsrc,iord,memtoreg,regdst,alucontrol}
  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b011;
    endcase
  endfunction

  function automatic logic [14:0] exp_out(input int st, input logic rst_n,
                                          input logic [5:0] fn, input logic z);
    logic pcw, br, mw, ir, rw, sa, io, m2r, rd;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    int s;
    s = rst_n ? st : 0;
    {pcw, br, mw, ir, rw, sa, io, m2r, rd} = '0;
    sb = 2'b00; ps = 2'b00; alu = 3'b010;
    case (s)
      0:  begin ir = 1; pcw = 1; sb = 2'b01; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  io = 1;
      4:  begin rw = 1; m2r = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin sa = 1; alu = funct_alu(fn); end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; alu = 3'b110; ps = 2'b01; br = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {rst_n & (pcw | (br & z)), rst_n & mw, rst_n & ir, rst_n & rw,
            sa, sb, ps, io, m2r, rd, alu};
  endfunction

  // Step sequence of one instruction from FETCH up to (not including) the next FETCH.
  task automatic build_seq(input logic [5:0] o);
    case (o)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b000100: seq = '{0, 1, 8};
      6'b001000: seq = '{0, 1, 9, 10};
      6'b000010: seq = '{0, 1, 11};
      default:   seq = '{0, 1};
    endcase
  endtask

  // One clock: drive zero (random when zmode<0), sample on falling edge, advance.
  task automatic run_cycle(input int exp_st, input int zmode, input string tag);
    logic [14:0] got, want;
    zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
    @(negedge clk);
    checks++;
    assert (state === 4'(exp_st))
      else begin
        errors++;
        $error("FAIL %s state: got %0d expected %0d", tag, state, exp_st);
      end
    got  = {pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, pcsrc,
            iord, memtoreg, regdst, alucontrol};
    want = exp_out(exp_st, reset, funct, zero);
    checks++;
    assert (got === want)
      else begin
        errors++;
        $error("FAIL %s outputs(st=%0d op=%b fn=%b z=%b rst=%b): got %b expected %b",
               tag, exp_st, op, funct, zero, reset, got, want);
      end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] fn,
                           input int zmode, input string tag);
    op = o;
    funct = fn;
    build_seq(o);
    foreach (seq[i]) run_cycle(seq[i], zmode, tag);
  endtask

  logic [5:0] legal_ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  logic [5:0] functs    [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

  initial begin
    logic [5:0] o, fn;
    int k;
    reset = 1'b0; op = 6'b0; funct = 6'b0; zero = 1'b0;

    // Reset from an unknown state: two clocks low, strobes masked, then FETCH.
    @(posedge clk); #1;
    run_cycle(0, 0, "reset_hold");
    run_cycle(0, 1, "reset_hold2");
    reset = 1'b1;

    // Directed instructions.
    run_instr(6'b100011, 6'b0, -1, "lw");
    run_instr(6'b101011, 6'b0, -1, "sw");
    foreach (functs[i]) run_instr(6'b000000, functs[i], -1, "rtype");
    run_instr(6'b000100, 6'b0, 1, "beq_taken");
    run_instr(6'b000100, 6'b0, 0, "beq_not_taken");
    run_instr(6'b001000, 6'b0, -1, "addi");
    run_instr(6'b000010, 6'b0, -1, "j");
    run_instr(6'b111111, 6'b0, -1, "illegal");

    // Reset asserted during MEMRD of a lw: aborts with no write-back.
    op = 6'b100011; funct = 6'b0;
    run_cycle(0, -1, "abort_lw");
    run_cycle(1, -1, "abort_lw");
    run_cycle(2, -1, "abort_lw");
    reset = 1'b0;
    run_cycle(3, -1, "abort_memrd");
    run_cycle(0, -1, "abort_hold");
    reset = 1'b1;
    run_instr(6'b101011, 6'b0, -1, "after_abort");

    // Random instruction stream with occasional two-cycle resets mid-instruction.
    for (int n = 0; n < 200; n++) begin
      o  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 5)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) == 0) begin
        op = o; funct = fn;
        build_seq(o);
        k = $urandom_range(0, seq.size() - 1);
        for (int i = 0; i < k; i++) run_cycle(seq[i], -1, "rand_pre_abort");
        reset = 1'b0;
        run_cycle(seq[k], -1, "rand_abort");
        run_cycle(0, -1, "rand_abort_hold");
        reset = 1'b1;
      end else begin
        run_instr(o, fn, -1, "random");
      end
    end

    // Final instruction boundary lands back in FETCH.
    run_cycle(0, -1, "final_fetch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
- Control unit for the multicycle MIPS datapath; produces every datapath enable and mux select, plus the 3-bit ALU operation code.
- Moore FSM, one state per instruction step, plus a combinational ALU decoder driven by opcode and funct.
- Sits between the instruction register (op, funct) and the ALU zero flag on one side, and the datapath muxes, write enables and ALU control on the other.

Parameters:
- none (opcode, funct and state encodings are fixed below)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low (0 = reset), sampled on rising clk
- op  in  6  instr[31:26] from instruction register
- funct  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag
- pcen  out  1  PC load enable = pcwrite | (branch & zero)
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write
- alusrca  out  1  0 = PC, 1 = register A
- alusrcb  out  2  00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- iord  out  1  0 = PC address, 1 = ALUOut address
- memtoreg  out  1  1 = write-back data from memory
- regdst  out  1  1 = rd, 0 = rt
- alucontrol  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- state  out  4  current state (debug)

Behaviour:
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11. Codes 12–15 are unreachable; if entered, next state is FETCH with all outputs 0.
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- Reset: reset==0 at a rising edge forces state to FETCH. While reset==0, force pcen, memwrite, irwrite and regwrite to 0 regardless of state. All other outputs follow FETCH decode. Reset mid-instruction aborts it with no further writes.
- Transitions:
  - FETCH -> DECODE
  - DECODE -> lw/sw: MEMADR; R: RTYPEEX; beq: BEQEX; addi: ADDIEX; j: JEX; any other op: FETCH (treated as nop)
  - MEMADR -> lw: MEMRD; sw: MEMWR
  - MEMRD -> MEMWB
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX -> FETCH
  - RTYPEEX -> RTYPEWB; ADDIEX -> ADDIWB
- Per-state outputs (anything not listed is 0):
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00
  - DECODE: alusrcb=11, aluop=00
  - MEMADR: alusrca=1, alusrcb=10, aluop=00
  - MEMRD: iord=1
  - MEMWB: regwrite=1, memtoreg=1, regdst=0
  - MEMWR: iord=1, memwrite=1
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10
  - RTYPEWB: regwrite=1, regdst=1
  - BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00
  - ADDIWB: regwrite=1, regdst=0
  - JEX: pcsrc=10, pcwrite=1
- aluop (internal) decode:
  - 00 -> alucontrol 010
  - 01 -> 110
  - 10 -> from funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, other funct -> 011 (ALU returns 0)
- Outputs are combinational from state, op, funct and zero; there is no output register. pcen depends on zero in the same cycle.
- Cycles per instruction, FETCH to next FETCH: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal op 2.

Test Plan:
- Hold reset=0 for 2 clk in any state -> state=0; pcen, memwrite, irwrite, regwrite all 0 while reset=0. Release -> FETCH outputs irwrite=1, pcen=1, alucontrol=010.
- op=100011 (lw) -> states 0,1,2,3,4,0; memwrite never 1; regwrite=1 only in state 4 with memtoreg=1, regdst=0; iord=1 in state 3.
- op=101011 (sw) -> states 0,1,2,5,0; memwrite=1 only in state 5; regwrite never 1.
- op=000000, funct 100000/100010/100100/100101/101010/000000 -> in RTYPEEX alucontrol = 010/110/000/001/111/011; RTYPEWB regwrite=1, regdst=1.
- op=000100 (beq): zero=1 in BEQEX -> pcen=1, pcsrc=01, alucontrol=110. Repeat with zero=0 -> pcen=0; next state FETCH in both cases.
- op=000010 -> JEX pcen=1, pcsrc=10. op=111111 -> DECODE then FETCH with no write strobes. Assert reset=0 during MEMRD of a lw -> next state FETCH and no regwrite pulse.
